// File: rtl/led_pulse_monitor.sv
// led_pulse_monitor: glitch-filtered LED pattern change detector.
// Emits {pattern, interval} events into a small valid/ready FIFO.
module led_pulse_monitor #(
    parameter int STABLE_CYCLES = 3,
    parameter int DEPTH         = 4,
    parameter int IW            = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    led_i,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [7:0]    evt_led,
    output logic [IW-1:0] evt_interval,
    output logic [15:0]   evt_count,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(STABLE_CYCLES + 1);
    localparam bit SINGLE = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_STABLE,
        S_CAND
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_sync1;
    logic [7:0]    r_sync2;
    logic [7:0]    w_led_s;
    logic [1:0]    r_init_cnt;
    logic [7:0]    r_stable;
    logic [7:0]    r_cand;
    logic [HW-1:0] r_hold;
    logic [IW-1:0] r_interval;
    logic [15:0]   r_count;
    logic          r_ovf;

    logic [7:0]    r_mem_led [DEPTH];
    logic [IW-1:0] r_mem_int [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;

    logic w_init_exit;
    logic w_accept;
    logic w_load_cand;
    logic w_hold_inc;
    logic w_hold_done;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_led_s     = r_sync2;
    assign w_hold_done = (r_hold == HW'(STABLE_CYCLES - 1));

    // Two-flop synchronizer for the asynchronous LED bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= led_i;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT: begin
                if (r_init_cnt == 2'd2) begin
                    w_state_nxt = S_STABLE;
                end
            end
            S_STABLE: begin
                if (w_led_s != r_stable && !SINGLE) begin
                    w_state_nxt = S_CAND;
                end
            end
            S_CAND: begin
                if (w_led_s == r_cand) begin
                    if (w_hold_done) begin
                        w_state_nxt = S_STABLE;
                    end
                end else if (w_led_s == r_stable) begin
                    w_state_nxt = S_STABLE;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    // FSM outputs: strobes for the datapath
    always_comb begin
        w_init_exit = 1'b0;
        w_accept    = 1'b0;
        w_load_cand = 1'b0;
        w_hold_inc  = 1'b0;
        case (r_state)
            S_INIT: begin
                w_init_exit = (r_init_cnt == 2'd2);
            end
            S_STABLE: begin
                if (w_led_s != r_stable) begin
                    w_load_cand = 1'b1;
                    w_accept    = SINGLE;
                end
            end
            S_CAND: begin
                if (w_led_s == r_cand) begin
                    w_accept   = w_hold_done;
                    w_hold_inc = !w_hold_done;
                end else if (w_led_s != r_stable) begin
                    w_load_cand = 1'b1;
                end
            end
            default: begin
                w_init_exit = 1'b0;
            end
        endcase
    end

    // Detector datapath: baseline, candidate, hold count, interval, count
    // On accept the candidate equals led_s, so led_s is the accepted value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_cnt <= '0;
            r_stable   <= '0;
            r_cand     <= '0;
            r_hold     <= '0;
            r_interval <= '0;
            r_count    <= '0;
        end else begin
            if (r_state == S_INIT && r_init_cnt != 2'd2) begin
                r_init_cnt <= r_init_cnt + 2'd1;
            end
            if (w_load_cand) begin
                r_cand <= w_led_s;
                r_hold <= HW'(1);
            end else if (w_hold_inc) begin
                r_hold <= r_hold + HW'(1);
            end
            if (w_init_exit) begin
                r_stable   <= w_led_s;
                r_interval <= '0;
            end else if (w_accept) begin
                r_stable   <= w_led_s;
                r_interval <= IW'(1);
                r_count    <= r_count + 16'd1;
            end else if (r_state != S_INIT && r_interval != '1) begin
                r_interval <= r_interval + IW'(1);
            end
        end
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && evt_ready;
    assign w_push  = w_accept && (!w_full || w_pop);
    assign w_drop  = w_accept && w_full && !w_pop;

    // Event FIFO: pop and push may coincide, even when full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_led[i] <= '0;
                r_mem_int[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push) begin
                r_mem_led[r_wptr[AW-1:0]] <= w_led_s;
                r_mem_int[r_wptr[AW-1:0]] <= r_interval;
                r_wptr <= r_wptr + 1'b1;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle beats the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign evt_valid    = !w_empty;
    assign evt_led      = r_mem_led[r_rptr[AW-1:0]];
    assign evt_interval = r_mem_int[r_rptr[AW-1:0]];
    assign evt_count    = r_count;
    assign overflow     = r_ovf;

endmodule
